// File: rtl/opb_bus_arbiter.sv
// Round-robin arbiter sharing the OPB master port; one single-beat access per grant.
// Optional macro OPB_ARB_LOCK_EN adds REQ_LOCK for atomic back-to-back ownership.
module opb_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      OPB_CLK,
    input  logic                      OPB_RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WR,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
`ifdef OPB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        REQ_LOCK,
`endif
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      BUSY,
    output logic                      OPB_RE,
    output logic                      OPB_WE,
    output logic [ADDR_W-1:0]         OPB_ADDR,
    output logic [DATA_W-1:0]         OPB_DI,
    input  logic [DATA_W-1:0]         OPB_DO
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic          wr_q;
    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic          lock_hit;

    // Lowest offset from the pointer wins, so scan offsets from high to low.
    function automatic logic [IW:0] pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IW-1:0]      p
    );
        logic          vld;
        logic [IW-1:0] idx;
        int            j;
        vld = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
        return {vld, idx};
    endfunction

    always_comb begin
        {win_vld, win_idx} = pick(REQ, ptr);
    end

`ifdef OPB_ARB_LOCK_EN
    assign lock_hit = REQ_LOCK[owner];
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner    <= '0;
            wr_q     <= 1'b0;
            GNT      <= '0;
            ACK      <= '0;
            RDATA    <= '0;
            BUSY     <= 1'b0;
            OPB_RE   <= 1'b0;
            OPB_WE   <= 1'b0;
            OPB_ADDR <= '0;
            OPB_DI   <= '0;
        end else begin
            ACK    <= '0;
            OPB_RE <= 1'b0;
            OPB_WE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        owner    <= win_idx;
                        wr_q     <= REQ_WR[win_idx];
                        OPB_ADDR <= REQ_ADDR[win_idx*ADDR_W +: ADDR_W];
                        OPB_DI   <= REQ_WDATA[win_idx*DATA_W +: DATA_W];
                        OPB_RE   <= ~REQ_WR[win_idx];
                        OPB_WE   <= REQ_WR[win_idx];
                        GNT      <= NUM_REQ'(1) << win_idx;
                        BUSY     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wr_q) begin
                        ACK   <= GNT;
                        state <= S_DONE;
                    end else begin
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    RDATA <= OPB_DO;
                    ACK   <= GNT;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // A locked owner keeps the pointer, so it wins the next scan.
                    if (lock_hit)
                        ptr <= owner;
                    else if (owner == IW'(NUM_REQ - 1))
                        ptr <= '0;
                    else
                        ptr <= owner + IW'(1);
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_bus_arbiter.sv
// Self-checking bench for opb_bus_arbiter: directed cases plus random traffic
// checked against a transaction-level round-robin model.
module tb_opb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              OPB_CLK = 1'b0;
    logic              OPB_RST;
    logic [N-1:0]      REQ;
    logic [N-1:0]      REQ_WR;
    logic [N*AW-1:0]   REQ_ADDR;
    logic [N*DW-1:0]   REQ_WDATA;
`ifdef OPB_ARB_LOCK_EN
    logic [N-1:0]      REQ_LOCK;
`endif
    logic [N-1:0]      GNT;
    logic [N-1:0]      ACK;
    logic [DW-1:0]     RDATA;
    logic              BUSY;
    logic              OPB_RE;
    logic              OPB_WE;
    logic [AW-1:0]     OPB_ADDR;
    logic [DW-1:0]     OPB_DI;
    logic [DW-1:0]     OPB_DO;

    int n_chk  = 0;
    int n_fail = 0;

    logic          re_d = 1'b0;
    logic [AW-1:0] addr_d = '0;

    always #5 OPB_CLK = ~OPB_CLK;

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        return a ^ 32'h1234_5478;
    endfunction

    // Decoder model: data valid only in the cycle after the read strobe.
    always @(posedge OPB_CLK) begin
        re_d   <= OPB_RE;
        addr_d <= OPB_ADDR;
    end
    assign OPB_DO = re_d ? rd_val(addr_d) : 32'hDEAD_BEEF;

    opb_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .OPB_CLK   (OPB_CLK),
        .OPB_RST   (OPB_RST),
        .REQ       (REQ),
        .REQ_WR    (REQ_WR),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
`ifdef OPB_ARB_LOCK_EN
        .REQ_LOCK  (REQ_LOCK),
`endif
        .GNT       (GNT),
        .ACK       (ACK),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .OPB_RE    (OPB_RE),
        .OPB_WE    (OPB_WE),
        .OPB_ADDR  (OPB_ADDR),
        .OPB_DI    (OPB_DI),
        .OPB_DO    (OPB_DO)
    );

    task automatic tick();
        @(posedge OPB_CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ[i]               = 1'b1;
        REQ_WR[i]            = wr;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_WDATA[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        REQ     = '0;
        OPB_RST = 1'b1;
        tick();
        OPB_RST = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        OPB_RST   = 1'b1;
        REQ       = '0;
        REQ_WR    = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
`ifdef OPB_ARB_LOCK_EN
        REQ_LOCK  = '0;
`endif
        repeat (2) tick();
        n_chk++;
        if ({GNT, ACK, RDATA, BUSY, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b ack=%b busy=%b re=%b we=%b addr=%h di=%h rdata=%h, required all 0",
                     GNT, ACK, BUSY, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI, RDATA);
        end
        OPB_RST = 1'b0;
        repeat (2) tick();
        n_chk++;
        if (BUSY !== 1'b0 || GNT !== '0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b gnt=%b, required 0 0", BUSY, GNT);
        end
    endtask

    task automatic test_write();
        set_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
        tick();
        n_chk++;
        if (OPB_WE !== 1'b1 || OPB_RE !== 1'b0 || GNT !== 4'b0001 || ACK !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_issue: we=%b re=%b gnt=%b ack=%b, required 1 0 0001 0000",
                     OPB_WE, OPB_RE, GNT, ACK);
        end
        n_chk++;
        if (OPB_ADDR !== 32'h10 || OPB_DI !== 32'hA5A5_5A5A) begin
            n_fail++;
            $display("FAIL write_bus: addr=%h di=%h, required 00000010 a5a55a5a", OPB_ADDR, OPB_DI);
        end
        tick();
        n_chk++;
        if (ACK !== 4'b0001 || OPB_WE !== 1'b0 || OPB_RE !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack: ack=%b we=%b re=%b, required 0001 0 0", ACK, OPB_WE, OPB_RE);
        end
        REQ[0] = 1'b0;
        tick();
        n_chk++;
        if (ACK !== 4'b0000 || BUSY !== 1'b0 || OPB_ADDR !== 32'h10) begin
            n_fail++;
            $display("FAIL write_end: ack=%b busy=%b addr=%h, required 0000 0 00000010", ACK, BUSY, OPB_ADDR);
        end
    endtask

    task automatic test_read();
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        tick();
        n_chk++;
        if (OPB_RE !== 1'b1 || OPB_WE !== 1'b0 || GNT !== 4'b0010 || OPB_ADDR !== 32'h200) begin
            n_fail++;
            $display("FAIL read_issue: re=%b we=%b gnt=%b addr=%h, required 1 0 0010 00000200",
                     OPB_RE, OPB_WE, GNT, OPB_ADDR);
        end
        tick();
        n_chk++;
        if (OPB_RE !== 1'b0 || ACK !== 4'b0000 || GNT !== 4'b0010) begin
            n_fail++;
            $display("FAIL read_capt: re=%b ack=%b gnt=%b, required 0 0000 0010", OPB_RE, ACK, GNT);
        end
        tick();
        n_chk++;
        if (ACK !== 4'b0010 || RDATA !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_ack: ack=%b rdata=%h, required 0010 12345678", ACK, RDATA);
        end
        REQ[1] = 1'b0;
        tick();
        n_chk++;
        if (ACK !== 4'b0000 || RDATA !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_hold: ack=%b rdata=%h, required 0000 12345678", ACK, RDATA);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [5];
        int           re_per [5];
        int           ng = 0;
        logic [N-1:0] prev = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            seq[i]    = '0;
            re_per[i] = 0;
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 * i, 32'h0);
        for (int c = 0; c < 60 && ng < 5; c++) begin
            tick();
            if (GNT != '0 && prev == '0) begin
                seq[ng] = GNT;
                ng++;
            end
            if (OPB_RE === 1'b1 && ng >= 1) re_per[ng-1]++;
            prev = GNT;
        end
        n_chk++;
        if (ng != 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: grants=%0d, required 5 within budget", ng);
        end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (seq[k] !== 4'(1 << (k % N)) || re_per[k] != 1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: gnt=%b re_count=%0d, required %b 1",
                         k, seq[k], re_per[k], 4'(1 << (k % N)));
            end
        end
        REQ = '0;
        repeat (5) tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        set_req(0, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        OPB_RST = 1'b1;
        #1;
        n_chk++;
        if ({GNT, ACK, RDATA, BUSY, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: gnt=%b ack=%b busy=%b addr=%h rdata=%h, required all 0",
                     GNT, ACK, BUSY, OPB_ADDR, RDATA);
        end
        REQ = '0;
        set_req(2, 1'b0, 32'h300, 32'h0);
        tick();
        n_chk++;
        if (ACK !== '0 || OPB_RE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_ack: ack=%b re=%b, required 0000 0", ACK, OPB_RE);
        end
        OPB_RST = 1'b0;
        tick();
        n_chk++;
        if (GNT !== 4'b0100 || OPB_RE !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_regrant: gnt=%b re=%b, required 0100 1", GNT, OPB_RE);
        end
        tick();
        tick();
        n_chk++;
        if (ACK !== 4'b0100 || RDATA !== rd_val(32'h300)) begin
            n_fail++;
            $display("FAIL abort_read_ack: ack=%b rdata=%h, required 0100 %h", ACK, RDATA, rd_val(32'h300));
        end
        REQ = '0;
        tick();
    endtask

    task automatic test_drop_after_grant();
        int we_cnt = 0;
        int ack_cnt = 0;
        set_req(3, 1'b1, 32'h0000_0ABC, 32'hCAFE_F00D);
        tick();
        REQ[3] = 1'b0;
        if (OPB_WE === 1'b1) we_cnt++;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (OPB_WE === 1'b1) we_cnt++;
            if (ACK === 4'b1000) ack_cnt++;
        end
        n_chk++;
        if (we_cnt != 1 || ack_cnt != 1) begin
            n_fail++;
            $display("FAIL drop_after_grant: we_pulses=%0d acks=%0d, required 1 1", we_cnt, ack_cnt);
        end
        n_chk++;
        if (BUSY !== 1'b0 || GNT !== '0) begin
            n_fail++;
            $display("FAIL drop_idle: busy=%b gnt=%b, required 0 0000", BUSY, GNT);
        end
    endtask

`ifdef OPB_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] seq [5];
        int           ng = 0;
        logic [N-1:0] prev = '0;
        do_reset();
        for (int i = 0; i < 5; i++) seq[i] = '0;
        REQ_LOCK = 4'b0001;
        set_req(0, 1'b1, 32'h500, 32'h1);
        set_req(1, 1'b1, 32'h600, 32'h2);
        for (int c = 0; c < 80 && ng < 5; c++) begin
            tick();
            if (GNT != '0 && prev == '0) begin
                seq[ng] = GNT;
                ng++;
                if (ng == 4) REQ_LOCK[0] = 1'b0;
            end
            prev = GNT;
        end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (seq[k] !== ((k < 4) ? 4'b0001 : 4'b0010)) begin
                n_fail++;
                $display("FAIL lock_grant%0d: gnt=%b, required %b",
                         k, seq[k], (k < 4) ? 4'b0001 : 4'b0010);
            end
        end
        REQ      = '0;
        REQ_LOCK = '0;
        repeat (5) tick();
    endtask
`endif

    task automatic test_random();
        int            ptr = 0;
        bit            busy = 0;
        int            owner = 0;
        int            pos = 0;
        int            len = 0;
        bit            m_wr = 0;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_data = '0;
        logic [N-1:0]  eg, ea;
        bit            ere, ewe;
        int            txn = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge OPB_CLK);
            if (!busy) begin
                if (REQ != '0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (REQ[(ptr + k) % N]) owner = (ptr + k) % N;
                    m_wr   = REQ_WR[owner];
                    m_addr = REQ_ADDR[owner*AW +: AW];
                    m_data = REQ_WDATA[owner*DW +: DW];
                    len    = m_wr ? 2 : 3;
                    pos    = 1;
                    busy   = 1;
                    txn++;
                end
            end else begin
                pos++;
                if (pos > len) begin
                    busy = 0;
                    ptr  = (owner + 1) % N;
                end
            end
            #1;
            eg  = busy ? N'(1) << owner : '0;
            ea  = (busy && pos == len) ? eg : '0;
            ere = busy && pos == 1 && !m_wr;
            ewe = busy && pos == 1 && m_wr;
            n_chk++;
            if (GNT !== eg || ACK !== ea || OPB_RE !== ere || OPB_WE !== ewe || BUSY !== busy) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d: gnt=%b ack=%b re=%b we=%b busy=%b, required %b %b %b %b %b",
                         c, GNT, ACK, OPB_RE, OPB_WE, BUSY, eg, ea, ere, ewe, busy);
            end
            if (busy) begin
                n_chk++;
                if (OPB_ADDR !== m_addr || OPB_DI !== m_data) begin
                    n_fail++;
                    $display("FAIL rand_bus cyc=%0d: addr=%h di=%h, required %h %h",
                             c, OPB_ADDR, OPB_DI, m_addr, m_data);
                end
            end
            if (ea != '0 && !m_wr) begin
                n_chk++;
                if (RDATA !== rd_val(m_addr)) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc=%0d: rdata=%h, required %h", c, RDATA, rd_val(m_addr));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (ea[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
                    else
                        REQ[i] = 1'b0;
                end else if (!REQ[i] && $urandom_range(3, 0) == 0) begin
                    set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
                end
            end
        end
        n_chk++;
        if (txn < 100) begin
            n_fail++;
            $display("FAIL rand_progress: transactions=%0d, required at least 100", txn);
        end
        REQ = '0;
        repeat (5) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_abort();
        test_drop_after_grant();
`ifdef OPB_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
